// File: rtl/brnch_pred_pkg.sv
// Types and helpers shared by the branch predictor and the ID-stage resolve/update logic.
package brnch_pred_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_e;

  localparam logic [31:0] PC_INCR = 32'd4;

  // Predictor index: word-aligned PC bits [idx_w+1:2], returned zero-extended.
  function automatic logic [31:0] pc_to_idx(input logic [31:0] pc, input int idx_w);
    logic [31:0] mask;
    mask = (32'd1 << idx_w) - 32'd1;
    return (pc >> 2) & mask;
  endfunction

endpackage

// File: rtl/brnch_resolve_update_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/brnch_resolve_update_ctrl.sv
// ID-stage branch resolution: compares the carried IF prediction with the resolved outcome,
// emits the predictor update, mispredict flush/redirect, and performance counters.
module brnch_resolve_update_ctrl
  import brnch_pred_pkg::*;
#(
  parameter int IDX_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_brch_detectd,
  input  logic             if_pred_taken,
  input  logic [31:0]      if_pc,
  input  logic             id_hazard_stall,
  input  logic             id_brch_cond_met,
  input  logic [31:0]      id_brch_target,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_idx,
  output logic             upd_result,
  output logic             mispredict_flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  state_e      state_q, state_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_pred_q, id_pred_d;
  logic        resolve;
  logic        mispredict;
  logic        capture;

  always_comb begin
    resolve    = (state_q == HELD) && !id_hazard_stall;
    mispredict = resolve && (id_brch_cond_met != id_pred_q);
    // An unstalled ID slot is free (EMPTY or resolving now); the IF branch behind a
    // mispredict is wrong-path and must be dropped.
    capture    = if_brch_detectd && !id_hazard_stall && !mispredict;

    state_d   = state_q;
    id_pc_d   = id_pc_q;
    id_pred_d = id_pred_q;
    if (capture) begin
      state_d   = HELD;
      id_pc_d   = if_pc;
      id_pred_d = if_pred_taken;
    end else if (resolve) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      id_pc_q   <= '0;
      id_pred_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_pc_q   <= id_pc_d;
      id_pred_q <= id_pred_d;
    end
  end

  assign upd_valid        = resolve;
  assign upd_idx          = resolve ? IDX_W'(pc_to_idx(id_pc_q, IDX_W)) : '0;
  assign upd_result       = resolve & id_brch_cond_met;
  assign mispredict_flush = mispredict;
  assign redirect_valid   = mispredict;
  assign redirect_pc      = !mispredict      ? 32'd0 :
                            id_brch_cond_met ? id_brch_target : (id_pc_q + PC_INCR);

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk (clk),
    .clr (rst),
    .inc (resolve),
    .cnt (br_count)
  );

  sat_counter #(.W(CNT_W)) u_mp_cnt (
    .clk (clk),
    .clr (rst),
    .inc (mispredict),
    .cnt (mispred_count)
  );

endmodule

// File: tb/tb_brnch_resolve_update_ctrl.sv
// Self-checking bench: directed vector table, reset/saturation sequences and random traffic
// checked against a queue-based model of the ID branch slot.
module tb_brnch_resolve_update_ctrl;

  localparam int IDX_W = 5;
  localparam int CNT_W = 16;
  localparam int CMAX  = 65535;

  logic        clk;
  logic        rst;
  logic        if_brch_detectd;
  logic        if_pred_taken;
  logic [31:0] if_pc;
  logic        id_hazard_stall;
  logic        id_brch_cond_met;
  logic [31:0] id_brch_target;
  logic        upd_valid;
  logic [4:0]  upd_idx;
  logic        upd_result;
  logic        mispredict_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] br_count;
  logic [15:0] mispred_count;

  brnch_resolve_update_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_brch_detectd  (if_brch_detectd),
    .if_pred_taken    (if_pred_taken),
    .if_pc            (if_pc),
    .id_hazard_stall  (id_hazard_stall),
    .id_brch_cond_met (id_brch_cond_met),
    .id_brch_target   (id_brch_target),
    .upd_valid        (upd_valid),
    .upd_idx          (upd_idx),
    .upd_result       (upd_result),
    .mispredict_flush (mispredict_flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .br_count         (br_count),
    .mispred_count    (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: the ID slot is a queue of at most one pending branch; counters are plain ints.
  typedef struct {
    logic [31:0] pc;
    logic        pred;
  } br_t;
  br_t pend[$];
  int  m_br = 0;
  int  m_mp = 0;

  logic        obs_uv, obs_res, obs_fl, obs_rv;
  logic [4:0]  obs_idx;
  logic [31:0] obs_rpc;
  logic [15:0] obs_br, obs_mp;

  typedef struct {
    logic        bd, pt;
    logic [31:0] pc;
    logic        st, cm;
    logic [31:0] tg;
    logic        uv;
    logic [4:0]  idx;
    logic        res, fl;
    logic [31:0] rpc;
    logic [15:0] br, mp;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, compare at the falling edge, then advance the model at the rising edge.
  task automatic cycle(input logic r, input logic bd, input logic pt, input logic [31:0] pc,
                       input logic st, input logic cm, input logic [31:0] tg);
    logic        res, mis;
    logic [31:0] e_idx, e_rpc;
    rst = r; if_brch_detectd = bd; if_pred_taken = pt; if_pc = pc;
    id_hazard_stall = st; id_brch_cond_met = cm; id_brch_target = tg;
    @(negedge clk);
    res   = (pend.size() != 0) && !st;
    mis   = res && (cm != pend[0].pred);
    e_idx = res ? (pend[0].pc / 4) % 32 : 0;
    e_rpc = !mis ? 32'd0 : (cm ? tg : pend[0].pc + 32'd4);
    obs_uv = upd_valid; obs_idx = upd_idx; obs_res = upd_result; obs_fl = mispredict_flush;
    obs_rv = redirect_valid; obs_rpc = redirect_pc; obs_br = br_count; obs_mp = mispred_count;
    chk("upd_valid", {31'd0, upd_valid}, {31'd0, res});
    chk("upd_idx", {27'd0, upd_idx}, e_idx);
    chk("upd_result", {31'd0, upd_result}, {31'd0, res & cm});
    chk("mispredict_flush", {31'd0, mispredict_flush}, {31'd0, mis});
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, mis});
    chk("redirect_pc", redirect_pc, e_rpc);
    chk("br_count", {16'd0, br_count}, m_br);
    chk("mispred_count", {16'd0, mispred_count}, m_mp);
    @(posedge clk);
    #1;
    if (r) begin
      pend.delete();
      m_br = 0;
      m_mp = 0;
    end else begin
      if (res) begin
        void'(pend.pop_front());
        if (m_br < CMAX) m_br++;
        if (mis && m_mp < CMAX) m_mp++;
      end
      if (bd && !st && !mis && pend.size() == 0) pend.push_back('{pc, pt});
    end
  endtask

  function automatic vec_t mk(logic bd, logic pt, logic [31:0] pc, logic st, logic cm,
                              logic [31:0] tg, logic uv, logic [4:0] idx, logic res,
                              logic fl, logic [31:0] rpc, logic [15:0] br, logic [15:0] mp);
    vec_t v;
    v.bd = bd; v.pt = pt; v.pc = pc; v.st = st; v.cm = cm; v.tg = tg;
    v.uv = uv; v.idx = idx; v.res = res; v.fl = fl; v.rpc = rpc; v.br = br; v.mp = mp;
    return v;
  endfunction

  initial begin
    logic [31:0] rpc_v;
    //            bd pt pc            st cm tg              uv idx res fl rpc           br mp
    tbl[0]  = mk(1, 1, 32'h00400010, 0, 0, 32'h0,         0, 0,  0, 0, 32'h0,        0, 0);
    tbl[1]  = mk(0, 0, 32'h0,        0, 1, 32'h0,         1, 4,  1, 0, 32'h0,        0, 0);
    tbl[2]  = mk(1, 0, 32'h00400020, 0, 0, 32'h0,         0, 0,  0, 0, 32'h0,        1, 0);
    tbl[3]  = mk(1, 1, 32'h00400024, 0, 1, 32'h00400100,  1, 8,  1, 1, 32'h00400100, 1, 0);
    tbl[4]  = mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 0,  0, 0, 32'h0,        2, 1);
    tbl[5]  = mk(1, 1, 32'hFFFFFFFC, 0, 0, 32'h0,         0, 0,  0, 0, 32'h0,        2, 1);
    tbl[6]  = mk(0, 0, 32'h0,        0, 0, 32'hDEADBEEF,  1, 31, 0, 1, 32'h0,        2, 1);
    tbl[7]  = mk(1, 1, 32'h00400030, 0, 0, 32'h0,         0, 0,  0, 0, 32'h0,        3, 2);
    tbl[8]  = mk(1, 0, 32'h00400090, 1, 1, 32'h0,         0, 0,  0, 0, 32'h0,        3, 2);
    tbl[9]  = mk(1, 0, 32'h00400090, 1, 0, 32'h0,         0, 0,  0, 0, 32'h0,        3, 2);
    tbl[10] = mk(1, 0, 32'h00400090, 1, 1, 32'h0,         0, 0,  0, 0, 32'h0,        3, 2);
    tbl[11] = mk(1, 1, 32'h00400040, 0, 1, 32'h0,         1, 12, 1, 0, 32'h0,        3, 2);
    tbl[12] = mk(1, 0, 32'h00400044, 0, 1, 32'h0,         1, 16, 1, 0, 32'h0,        4, 2);
    tbl[13] = mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 17, 0, 0, 32'h0,        5, 2);
    tbl[14] = mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 0,  0, 0, 32'h0,        6, 2);

    rst = 1'b1; if_brch_detectd = 1'b0; if_pred_taken = 1'b0; if_pc = '0;
    id_hazard_stall = 1'b0; id_brch_cond_met = 1'b0; id_brch_target = '0;
    repeat (2) @(posedge clk);
    #1;
    cycle(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      cycle(0, tbl[i].bd, tbl[i].pt, tbl[i].pc, tbl[i].st, tbl[i].cm, tbl[i].tg);
      $display("vec %0d: uv=%0b idx=%0d res=%0b flush=%0b rpc=%h br=%0d mp=%0d",
               i, obs_uv, obs_idx, obs_res, obs_fl, obs_rpc, obs_br, obs_mp);
      chk("tbl_uv", {31'd0, obs_uv}, {31'd0, tbl[i].uv});
      chk("tbl_idx", {27'd0, obs_idx}, {27'd0, tbl[i].idx});
      chk("tbl_res", {31'd0, obs_res}, {31'd0, tbl[i].res});
      chk("tbl_flush", {31'd0, obs_fl}, {31'd0, tbl[i].fl});
      chk("tbl_redir", {31'd0, obs_rv}, {31'd0, tbl[i].fl});
      chk("tbl_rpc", obs_rpc, tbl[i].rpc);
      chk("tbl_br", {16'd0, obs_br}, {16'd0, tbl[i].br});
      chk("tbl_mp", {16'd0, obs_mp}, {16'd0, tbl[i].mp});
    end

    // Reset while a branch is held: it must vanish without an update.
    cycle(0, 1, 1, 32'h00400050, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    $display("rst-held: uv=%0b br=%0d mp=%0d", obs_uv, obs_br, obs_mp);
    chk("rst_held_uv", {31'd0, obs_uv}, 32'd0);
    chk("rst_held_br", {16'd0, obs_br}, 32'd0);
    chk("rst_held_mp", {16'd0, obs_mp}, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom & 32'hFFFFFFFC, ($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom);
    end
    $display("random: done, br=%0d mp=%0d", m_br, m_mp);

    // Drive br_count up to the saturation point with back-to-back correct branches.
    cycle(1, 0, 0, 0, 0, 0, 0);
    while (m_br < CMAX - 2) begin
      cycle(0, 1, 1, $urandom & 32'hFFFFFFFC, 0, 1, $urandom);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 1, 32'h00400060 + 32'(i * 4), 0, 1, 32'h0);
    end
    $display("saturate: br=%h mp=%0d", obs_br, obs_mp);
    chk("sat_br", {16'd0, obs_br}, 32'h0000FFFF);
    chk("sat_mp", {16'd0, obs_mp}, 32'd0);

    // Reset while HELD after saturation.
    cycle(1, 0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    $display("rst-sat: uv=%0b br=%0d mp=%0d", obs_uv, obs_br, obs_mp);
    chk("rst_sat_uv", {31'd0, obs_uv}, 32'd0);
    chk("rst_sat_br", {16'd0, obs_br}, 32'd0);
    chk("rst_sat_mp", {16'd0, obs_mp}, 32'd0);

    // Wrap case exercised once more as a standalone redirect check.
    cycle(0, 1, 1, 32'hFFFFFFFC, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 32'h12345678);
    rpc_v = obs_rpc;
    $display("wrap: flush=%0b rpc=%h", obs_fl, rpc_v);
    chk("wrap_flush", {31'd0, obs_fl}, 32'd1);
    chk("wrap_rpc", rpc_v, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/brnch_resolve_update_ctrl.md
Name: brnch_resolve_update_ctrl

Overview:
- ID-stage branch resolution and predictor-update producer for the 5-stage MIPS pipeline.
- Carries each IF-stage branch prediction into ID and compares it with the resolved outcome there.
- Drives the update strobe, index and outcome consumed by the local-history branch predictor.
- On a mispredict, raises an IF/ID flush and a PC redirect. Keeps saturating branch and mispredict counters.

Parameters:
- IDX_W, 5, predictor index width; index = branch PC bits [IDX_W+1:2].
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_brch_detectd  in  1  branch instruction present in IF
- if_pred_taken  in  1  predictor output for the IF branch
- if_pc  in  32  PC of the IF instruction
- id_hazard_stall  in  1  ID stage stalled; IF/ID is also held
- id_brch_cond_met  in  1  resolved branch condition from the ID comparator
- id_brch_target  in  32  computed taken target in ID
- upd_valid  out  1  predictor update strobe
- upd_idx  out  IDX_W  predictor index for the update
- upd_result  out  1  actual outcome
- mispredict_flush  out  1  squash the IF/ID instruction
- redirect_valid  out  1  load PC with redirect_pc
- redirect_pc  out  32  corrected PC
- br_count  out  CNT_W  resolved branches
- mispred_count  out  CNT_W  mispredicted branches

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at an edge):
  - state -> EMPTY, captured pc/pred cleared, both counters = 0.
  - All combinational outputs read 0 while state is EMPTY.
  - A reset mid-HELD discards the pending branch with no update.
- FSM states:
  - EMPTY: no branch in ID.
  - HELD: branch in ID; id_pc and id_pred are registered.
- Capture:
  - At an edge with if_brch_detectd=1 and id_hazard_stall=0 and no mispredict this cycle: latch id_pc=if_pc, id_pred=if_pred_taken, and go to HELD.
  - This applies from EMPTY, and from HELD when the held branch resolves this cycle.
- Resolve (combinational, HELD and id_hazard_stall=0):
  - upd_valid=1.
  - upd_idx=id_pc[IDX_W+1:2].
  - upd_result=id_brch_cond_met.
- Exactly one upd_valid pulse per branch.
  - Stalled cycles: upd_valid=0 and state holds.
  - Stall across multiple cycles yields a single pulse on the first unstalled cycle.
- Mispredict = resolve & (id_brch_cond_met != id_pred).
  - mispredict_flush=1 and redirect_valid=1 in the same cycle.
  - redirect_pc = id_brch_cond_met ? id_brch_target : id_pc+4 (mod 2^32; wrap at 0xFFFFFFFC gives 0).
  - At that edge the IF branch is wrong-path: it is not captured and the next state is EMPTY.
- Correct prediction: flush and redirect stay 0; next state is HELD if a capture occurs, else EMPTY.
- Counters:
  - br_count increments on each resolve.
  - mispred_count increments on each mispredict.
  - Both saturate at all-ones and are registered, so the count is visible the cycle after the event.
- Back-to-back branches resolve on consecutive cycles with no bubble.
- id_brch_target is ignored unless resolving.
- No output depends on if_* inputs combinationally.

Decomposition:
- Shared package brnch_pred_pkg:
  - state enum {EMPTY, HELD}.
  - PC_INCR=32'd4.
  - index-extraction function used by both predictor and this block.
- One sub-module: sat_counter (CNT_W wide, inc, sync clear), instantiated twice.

Test Plan:
- Reset then a single branch:
  - Stimulus: if_pc=0x00400010, pred=1, then ID cond_met=1.
  - Response: upd_valid pulse, upd_idx=4, upd_result=1, no flush, br_count=1, mispred_count=0.
- Predicted not-taken, actually taken:
  - Stimulus: pc=0x00400020, pred=0, cond_met=1, target=0x00400100.
  - Response: flush=1, redirect_pc=0x00400100, mispred_count=1, IF branch that cycle not captured.
- Predicted taken, not taken:
  - Stimulus: pc=0xFFFFFFFC, pred=1, cond_met=0.
  - Response: redirect_pc=0x00000000.
- Stall of 3 cycles on a HELD branch:
  - Response: upd_valid=0 for 3 cycles, then exactly one pulse; br_count +1.
- Back-to-back branches at 0x00400040 and 0x00400044, both predicted correctly:
  - Response: upd_idx=16 then 17 on consecutive cycles, br_count=2.
- Saturation and reset:
  - Stimulus: preload br_count near all-ones, resolve 2 branches; then assert rst while HELD.
  - Response: br_count=0xFFFF; after rst, state EMPTY, counters 0, no upd_valid.
